// File: rtl/pong_pkg.sv
// pong_pkg: types and constants shared by the pong blocks.
//   dir_t        paddle movement direction (IDLE, UP, DOWN)
//   SCREEN_W/H   visible screen size in pixels
//   resolve_dir  maps debounced button levels plus freeze to a direction
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } dir_t;

  localparam int SCREEN_W = 800;
  localparam int SCREEN_H = 600;

  // Exactly one button held gives that direction. Both held, neither held,
  // or freeze asserted all give IDLE.
  function automatic dir_t resolve_dir(input logic up_held,
                                       input logic down_held,
                                       input logic hold_off);
    dir_t d;
    d = IDLE;
    if (!hold_off) begin
      if (up_held && !down_held) begin
        d = UP;
      end else if (down_held && !up_held) begin
        d = DOWN;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser and debouncer for one raw button.
//   PixelClock  in  clock, all logic on posedge
//   Reset       in  synchronous, active-high reset
//   i_btn_n     in  raw button, active-low, asynchronous to PixelClock
//   o_level     out debounced level, pressed-high
// Parameter DB_CYCLES: consecutive disagreeing samples needed to accept a change.
module btn_debounce
  import pong_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES = 16'd50000
) (
  input  logic PixelClock,
  input  logic Reset,
  input  logic i_btn_n,
  output logic o_level
);

  localparam int CW = $clog2(int'(DB_CYCLES) + 1);
  // The counter toggles the level on the sample that would bring it to
  // DB_CYCLES, so it never has to hold that value and cannot wrap.
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 16'd1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_pressed;

  // Synchroniser output inverted to pressed-high.
  assign w_pressed = ~r_sync2;

  always_ff @(posedge PixelClock) begin
    if (Reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      if (w_pressed != r_level) begin
        if (r_cnt == DB_LAST) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/paddle_input.sv
// paddle_input: turns two raw active-low push buttons into rate-limited
// single-cycle up/down strobes for one paddle's bar block.
//   PixelClock  in  pixel clock, all logic on posedge
//   Reset       in  synchronous, active-high reset
//   btnUpN      in  raw up button, active-low, asynchronous
//   btnDownN    in  raw down button, active-low, asynchronous
//   freeze      in  game paused/serving, suppresses all movement
//   up          out one-cycle move-up strobe
//   down        out one-cycle move-down strobe
//   upHeld      out debounced up-button level
//   downHeld    out debounced down-button level
// Parameters: DB_CYCLES (debounce length), MOVE_DIV (cycles between strobes),
// ACCEL_STEPS (strobes before the fast rate).
// Optional feature macro PADDLE_ACCEL_EN: after ACCEL_STEPS strobes in one
// direction the strobe period halves; without it the period is fixed.
module paddle_input
  import pong_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES   = 16'd50000,
  parameter logic [15:0] MOVE_DIV    = 16'd4000,
  parameter logic [7:0]  ACCEL_STEPS = 8'd32
) (
  input  logic PixelClock,
  input  logic Reset,
  input  logic btnUpN,
  input  logic btnDownN,
  input  logic freeze,
  output logic up,
  output logic down,
  output logic upHeld,
  output logic downHeld
);

  // Index 0 is the up button, index 1 the down button.
  logic [1:0] w_btn_n;
  logic [1:0] w_held;

  assign w_btn_n = {btnDownN, btnUpN};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_debounce (
      .PixelClock(PixelClock),
      .Reset     (Reset),
      .i_btn_n   (w_btn_n[gi]),
      .o_level   (w_held[gi])
    );
  end

  dir_t        r_dir;
  dir_t        w_dir_next;
  logic [15:0] r_rate_cnt;
  logic [15:0] w_period;
  logic        w_restart;
  logic        w_fire;
  logic        r_up;
  logic        r_down;

  always_ff @(posedge PixelClock) begin
    if (Reset) begin
      r_dir <= IDLE;
    end else begin
      r_dir <= w_dir_next;
    end
  end

  // w_restart: the rate counter (and step counter) start over whenever the
  // direction changes or we are idle, so a new run strobes immediately.
  // w_fire: a strobe is due in the current direction.
  always_comb begin
    w_dir_next = IDLE;
    w_restart  = 1'b0;
    w_fire     = 1'b0;
    w_dir_next = resolve_dir(w_held[0], w_held[1], freeze);
    w_restart  = (w_dir_next != r_dir) || (r_dir == IDLE);
    w_fire     = (r_dir != IDLE) && (r_rate_cnt == 16'd0);
  end

  always_ff @(posedge PixelClock) begin
    if (Reset) begin
      r_rate_cnt <= 16'd0;
    end else if (w_restart) begin
      r_rate_cnt <= 16'd0;
    end else if (r_rate_cnt >= w_period - 16'd1) begin
      r_rate_cnt <= 16'd0;
    end else begin
      r_rate_cnt <= r_rate_cnt + 16'd1;
    end
  end

`ifdef PADDLE_ACCEL_EN
  // Saturating count of strobes issued in the current run. The fast rate
  // takes effect for the gap following the ACCEL_STEPS-th strobe.
  logic [7:0] r_step_cnt;

  always_ff @(posedge PixelClock) begin
    if (Reset) begin
      r_step_cnt <= 8'd0;
    end else if (w_restart) begin
      r_step_cnt <= 8'd0;
    end else if (w_fire && (r_step_cnt != 8'hFF)) begin
      r_step_cnt <= r_step_cnt + 8'd1;
    end
  end

  assign w_period = (r_step_cnt >= ACCEL_STEPS) ? (MOVE_DIV >> 1) : MOVE_DIV;
`else
  logic w_unused_accel;
  assign w_unused_accel = |ACCEL_STEPS;
  assign w_period       = MOVE_DIV;
`endif

  // Direction is one-hot in the enum, so these can never both be set.
  always_ff @(posedge PixelClock) begin
    if (Reset) begin
      r_up   <= 1'b0;
      r_down <= 1'b0;
    end else begin
      r_up   <= w_fire && (r_dir == UP);
      r_down <= w_fire && (r_dir == DOWN);
    end
  end

  assign up       = r_up;
  assign down     = r_down;
  assign upHeld   = w_held[0];
  assign downHeld = w_held[1];

endmodule

// File: tb/tb_paddle_input.sv
// tb_paddle_input: directed steps plus randomized soak for paddle_input,
// checked every cycle against a behavioural model of the button rules.
// Honours PADDLE_ACCEL_EN for both the model and the acceleration step.
module tb_paddle_input;

  localparam logic [15:0] DB  = 16'd4;
  localparam logic [15:0] MV  = 16'd8;
  localparam logic [7:0]  AC  = 8'd3;
  localparam int          DBI = 4;
  localparam int          MVI = 8;
  localparam int          ACI = 3;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic up_n   = 1'b1;
  logic down_n = 1'b1;
  logic frz    = 1'b0;
  logic up;
  logic down;
  logic up_held;
  logic down_held;

  int checks   = 0;
  int failures = 0;

  paddle_input #(
    .DB_CYCLES  (DB),
    .MOVE_DIV   (MV),
    .ACCEL_STEPS(AC)
  ) dut (
    .PixelClock(clk),
    .Reset     (rst),
    .btnUpN    (up_n),
    .btnDownN  (down_n),
    .freeze    (frz),
    .up        (up),
    .down      (down),
    .upHeld    (up_held),
    .downHeld  (down_held)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Behavioural model. Buttons: index 0 up, 1 down. m_dir: 0 idle, 1 up, 2 down.
  logic m_raw1 [2];
  logic m_raw2 [2];
  logic m_held [2];
  int   m_run  [2];
  int   m_dir;
  bit   m_first;
  int   m_since;
  int   m_steps;
  logic m_up;
  logic m_down;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_raw1[b] = 1'b1;
      m_raw2[b] = 1'b1;
      m_held[b] = 1'b0;
      m_run[b]  = 0;
    end
    m_dir   = 0;
    m_first = 1'b1;
    m_since = 0;
    m_steps = 0;
    m_up    = 1'b0;
    m_down  = 1'b0;
  endtask

  function automatic int model_period();
`ifdef PADDLE_ACCEL_EN
    return (m_steps >= ACI) ? MVI / 2 : MVI;
`else
    return MVI;
`endif
  endfunction

  // One rising edge: outputs reflect the state before the edge, state
  // advances with the inputs present at the edge.
  task automatic model_edge();
    logic raw [2];
    int   nd;
    bit   fire;
    raw[0] = up_n;
    raw[1] = down_n;
    if (rst) begin
      model_reset();
      return;
    end
    fire   = (m_dir != 0) && (m_first || (m_since >= model_period()));
    m_up   = fire && (m_dir == 1);
    m_down = fire && (m_dir == 2);
    if (frz) nd = 0;
    else if (m_held[0] && !m_held[1]) nd = 1;
    else if (m_held[1] && !m_held[0]) nd = 2;
    else nd = 0;
    if ((nd != m_dir) || (nd == 0)) begin
      m_first = 1'b1;
      m_since = 0;
      m_steps = 0;
    end else if (fire) begin
      m_first = 1'b0;
      m_since = 1;
      if (m_steps < 255) m_steps++;
    end else begin
      m_since++;
    end
    m_dir = nd;
    for (int b = 0; b < 2; b++) begin
      if (!m_raw2[b] != m_held[b]) begin
        m_run[b]++;
        if (m_run[b] == DBI) begin
          m_held[b] = !m_held[b];
          m_run[b]  = 0;
        end
      end else begin
        m_run[b] = 0;
      end
      m_raw2[b] = m_raw1[b];
      m_raw1[b] = raw[b];
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("up", up, m_up);
    chk("down", down, m_down);
    chk("upHeld", up_held, m_held[0]);
    chk("downHeld", down_held, m_held[1]);
    chk("exclusive", up & down, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Edges until the chosen strobe is seen; -1 if the budget runs out.
  task automatic edges_to(input bit want_up, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if ((want_up ? up : down) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic count_strobes(input int ncyc, output int nu, output int nd);
    nu = 0;
    nd = 0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (up === 1'b1) nu++;
      if (down === 1'b1) nd++;
    end
  endtask

  int n;
  int nu;
  int nd;
  int len;
  int exp_u;

  initial begin
    model_reset();

    // 1: reset, then idle with buttons released
    ticks(3);
    rst = 1'b0;
    count_strobes(20, nu, nd);
    chk_int("t1_up_count", nu, 0);
    chk_int("t1_down_count", nd, 0);
    chk("t1_upHeld", up_held, 1'b0);
    $display("step1 idle: up=%0d down=%0d", nu, nd);

    // 2: glitch shorter than debounce is rejected
    len  = $urandom_range(1, DBI - 1);
    up_n = 1'b0;
    ticks(len);
    up_n = 1'b1;
    count_strobes(12, nu, nd);
    chk("t2_upHeld", up_held, 1'b0);
    chk_int("t2_up_count", nu, 0);
    $display("step2 glitch len=%0d: up=%0d", len, nu);

    // 3: held press, latency then regular strobes
    up_n = 1'b0;
    edges_to(1'b1, 20, n);
    chk_int("t3_first_latency", n, DBI + 4);
    edges_to(1'b1, 20, n);
    chk_int("t3_second_gap", n, MVI);
    count_strobes(24, nu, nd);
`ifdef PADDLE_ACCEL_EN
    exp_u = 5;
`else
    exp_u = 3;
`endif
    chk_int("t3_up_count", nu, exp_u);
    chk_int("t3_down_count", nd, 0);
    $display("step3 hold up: latency ok, window up=%0d down=%0d", nu, nd);
    up_n = 1'b1;
    ticks(10);

    // 4: both held gives no movement; releasing up lets down run
    up_n   = 1'b0;
    down_n = 1'b0;
    ticks(10);
    count_strobes(20, nu, nd);
    chk_int("t4_both_up", nu, 0);
    chk_int("t4_both_down", nd, 0);
    up_n = 1'b1;
    edges_to(1'b0, 20, n);
    chk_int("t4_down_latency", n, DBI + 4);
    $display("step4 conflict: strobes=%0d/%0d down_latency=%0d", nu, nd, n);
    down_n = 1'b1;
    ticks(12);

    // 5: freeze and reset during a hold
    up_n = 1'b0;
    edges_to(1'b1, 20, n);
    chk_int("t5_first_latency", n, DBI + 4);
    ticks($urandom_range(3, 12));
    frz = 1'b1;
    tick();
    count_strobes(9, nu, nd);
    chk_int("t5_frozen_up", nu, 0);
    frz = 1'b0;
    edges_to(1'b1, 5, n);
    chk_int("t5_unfreeze_latency", n, 2);
    ticks($urandom_range(1, 10));
    rst = 1'b1;
    ticks(2);
    chk("t5_rst_up", up, 1'b0);
    chk("t5_rst_held", up_held, 1'b0);
    rst = 1'b0;
    edges_to(1'b1, 20, n);
    chk_int("t5_post_reset_latency", n, DBI + 4);
    $display("step5 freeze/reset: post_reset_latency=%0d", n);
    up_n = 1'b1;
    ticks(12);

`ifdef PADDLE_ACCEL_EN
    // 6: acceleration, and its reset by a brief release
    begin
      int last;
      int gaps [5];
      int k;
      up_n = 1'b0;
      last = -1;
      k    = 0;
      for (int i = 0; i < 100 && k < 5; i++) begin
        tick();
        if (up === 1'b1) begin
          if (last >= 0) begin
            gaps[k] = i - last;
            k++;
          end
          last = i;
        end
      end
      chk_int("t6_gaps_found", k, 5);
      chk_int("t6_gap1", gaps[0], MVI);
      chk_int("t6_gap2", gaps[1], MVI);
      chk_int("t6_gap3", gaps[2], MVI / 2);
      chk_int("t6_gap4", gaps[3], MVI / 2);
      $display("step6 accel gaps: %0d %0d %0d %0d %0d", gaps[0], gaps[1], gaps[2], gaps[3], gaps[4]);
      up_n = 1'b1;
      ticks(DBI + 3);
      up_n = 1'b0;
      last = -1;
      k    = 0;
      for (int i = 0; i < 60 && k < 2; i++) begin
        tick();
        if (up === 1'b1) begin
          if (last >= 0) begin
            gaps[k] = i - last;
            k++;
          end
          last = i;
        end
      end
      chk_int("t6_regaps_found", k, 2);
      chk_int("t6_regap1", gaps[0], MVI);
      chk_int("t6_regap2", gaps[1], MVI);
      $display("step6 after release gaps: %0d %0d", gaps[0], gaps[1]);
      up_n = 1'b1;
      ticks(12);
    end
`endif

    // Randomized soak, checked cycle by cycle against the model
    for (int seg = 0; seg < 120; seg++) begin
      up_n   = ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
      down_n = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      frz    = ($urandom_range(0, 4) == 0);
      rst    = ($urandom_range(0, 39) == 0);
      len    = $urandom_range(1, 20);
      if (rst) begin
        ticks($urandom_range(1, 2));
        rst = 1'b0;
      end
      ticks(len);
      $display("soak seg=%0d up_n=%0b down_n=%0b freeze=%0b len=%0d", seg, up_n, down_n, frz, len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
